// File: rtl/npu_popcnt_pkg.sv
// npu_popcnt_pkg: shared constants, state enum and saturating thermometer function for the popcount path
package npu_popcnt_pkg;
    localparam int N_BITS = 13;
    localparam int CNT_W  = 4;

    typedef enum logic {IDLE, EMIT} state_t;

    function automatic logic [N_BITS-1:0] thermometer(input logic [CNT_W-1:0] c);
        logic [N_BITS-1:0] ones;
        logic [CNT_W-1:0] s;
        ones = '1;
        s = (c > CNT_W'(N_BITS)) ? CNT_W'(N_BITS) : c;
        return ~(ones << s);
    endfunction
endpackage

// File: rtl/popcount_expander_if.sv
// popcount_expander_if: count-in handshake, mask outputs and serial bit-stream handshake (master drives counts, slave is the expander)
interface popcount_expander_if;
    import npu_popcnt_pkg::*;
    logic              in_valid;
    logic              in_ready;
    logic [CNT_W-1:0]  in_count;
    logic [N_BITS-1:0] mask;
    logic              mask_valid;
    logic              count_err;
    logic              bit_valid;
    logic              bit_ready;
    logic              bit_out;
    logic              bit_last;

    modport master (
        output in_valid, in_count, bit_ready,
        input  in_ready, mask, mask_valid, count_err, bit_valid, bit_out, bit_last
    );

    modport slave (
        input  in_valid, in_count, bit_ready,
        output in_ready, mask, mask_valid, count_err, bit_valid, bit_out, bit_last
    );
endinterface

// File: rtl/thermo_decode.sv
// thermo_decode: count -> saturating N-bit thermometer mask (bit i set iff i < min(count, N))
module thermo_decode
    import npu_popcnt_pkg::*;
(
    input  logic [CNT_W-1:0]  count,
    output logic [N_BITS-1:0] mask
);
    assign mask = thermometer(count);
endmodule

// File: rtl/popcount_expander.sv
// popcount_expander: latches a count, presents its thermometer mask and streams it serially (clk, rst, bus.slave)
module popcount_expander
    import npu_popcnt_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    popcount_expander_if.slave bus
);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N_BITS - 1);
    localparam logic [CNT_W-1:0] MAXC = CNT_W'(N_BITS);

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  idx, idx_nxt, cnt;
    logic [N_BITS-1:0] mask_d, mask_q;
    logic              mask_valid_q, err_q;
    logic              accept, hs, last;

    thermo_decode u_thermo (
        .count (bus.in_count),
        .mask  (mask_d)
    );

    assign bus.in_ready   = (state == IDLE) && !rst;
    assign bus.bit_valid  = (state == EMIT);
    assign last           = (idx == LAST);
    assign bus.bit_out    = bus.bit_valid && (idx < cnt);
    assign bus.bit_last   = bus.bit_valid && last;
    assign bus.mask       = mask_q;
    assign bus.mask_valid = mask_valid_q;
    assign bus.count_err  = err_q;
    assign accept         = bus.in_valid && bus.in_ready;
    assign hs             = bus.bit_valid && bus.bit_ready;

    always_comb begin
        state_nxt = accept ? EMIT : (hs && last) ? IDLE : state;
        idx_nxt   = accept ? '0 : hs ? (last ? '0 : idx + 1'b1) : idx;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            idx          <= '0;
            cnt          <= '0;
            mask_q       <= '0;
            mask_valid_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
            if (accept) begin
                cnt          <= (bus.in_count > MAXC) ? MAXC : bus.in_count;
                err_q        <= bus.in_count > MAXC;
                mask_q       <= mask_d;
                mask_valid_q <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_popcount_expander.sv
// tb_popcount_expander: randomized self-checking bench against a behavioural expansion model
module tb_popcount_expander;
    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;

    popcount_expander_if bus ();

    popcount_expander dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Accept count c, then collect its stream under random backpressure.
    // next_c >= 0 keeps in_valid high with a new count during the stream.
    task automatic run_stream(input int c, input int ready_pct, input int next_c);
        int          sat, hs, cyc;
        logic [12:0] exp_mask, rx;
        logic        pb_out, pb_last;
        bit          stalled;
        sat      = (c > 13) ? 13 : c;
        exp_mask = 13'((1 << sat) - 1);
        rx       = '0;
        hs       = 0;
        cyc      = 0;
        stalled  = 0;
        pb_out   = 0;
        pb_last  = 0;
        check("idle_ready", bus.in_ready, 1);
        bus.in_valid = 1;
        bus.in_count = 4'(c);
        @(posedge clk); #1;
        if (next_c >= 0) bus.in_count = 4'(next_c);
        else bus.in_valid = 0;
        check("mask", bus.mask, exp_mask);
        check("mask_valid", bus.mask_valid, 1);
        check("count_err", bus.count_err, c > 13);
        while (hs < 13 && cyc < 400) begin
            cyc++;
            bus.bit_ready = ($urandom_range(99) < ready_pct);
            if (stalled) begin
                check("stall_out", bus.bit_out, pb_out);
                check("stall_last", bus.bit_last, pb_last);
            end
            check("bit_valid", bus.bit_valid, 1);
            check("busy", bus.in_ready, 0);
            if (next_c >= 0) check("mask_hold", bus.mask, exp_mask);
            if (bus.bit_ready) begin
                rx[hs] = bus.bit_out;
                check("bit_last", bus.bit_last, hs == 12);
                hs++;
                stalled = 0;
            end else begin
                stalled = 1;
                pb_out  = bus.bit_out;
                pb_last = bus.bit_last;
            end
            @(posedge clk); #1;
        end
        if (cyc >= 400) check("timeout", 0, 1);
        bus.bit_ready = 0;
        check("stream", rx, exp_mask);
        check("ready_back", bus.in_ready, 1);
        check("valid_end", bus.bit_valid, 0);
        check("mask_keep", bus.mask, exp_mask);
        check("mask_valid_keep", bus.mask_valid, 1);
        if (ready_pct >= 100) check("latency", cyc + 1, 14);
    endtask

    initial begin
        rst           = 1;
        bus.in_valid  = 0;
        bus.in_count  = 0;
        bus.bit_ready = 0;
        repeat (3) @(posedge clk);
        #1 rst = 0;
        #1;
        check("rst_mask", bus.mask, 0);
        check("rst_mask_valid", bus.mask_valid, 0);
        check("rst_err", bus.count_err, 0);
        check("rst_bit_valid", bus.bit_valid, 0);
        check("rst_bit_out", bus.bit_out, 0);
        check("rst_bit_last", bus.bit_last, 0);
        check("rst_in_ready", bus.in_ready, 1);

        run_stream(5, 100, -1);
        run_stream(0, 100, -1);
        run_stream(13, 100, -1);
        run_stream(15, 100, -1);
        run_stream(3, 100, -1);
        run_stream(7, 50, -1);

        bus.bit_ready = 1;
        bus.in_valid  = 1;
        bus.in_count  = 9;
        @(posedge clk); #1;
        bus.in_valid = 0;
        repeat (6) @(posedge clk);
        #1;
        check("pre_rst_bit", bus.bit_out, 1);
        check("pre_rst_last", bus.bit_last, 0);
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
        #1;
        bus.bit_ready = 0;
        check("abort_valid", bus.bit_valid, 0);
        check("abort_mask", bus.mask, 0);
        check("abort_ready", bus.in_ready, 1);
        run_stream(2, 100, -1);

        run_stream(6, 100, 4);
        run_stream(4, 70, -1);

        for (int c = 0; c <= 13; c++) begin
            run_stream(c, 100, -1);
            check("loopback", $countones(bus.mask), c);
        end

        for (int i = 0; i < 25; i++) begin
            run_stream(int'($urandom_range(15)), int'($urandom_range(100, 30)), -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/popcount_expander.md
Name: popcount_expander

Overview:
- Inverse of the 13-to-4 compressor adder: takes a 4-bit population count and regenerates a canonical 13-bit unary pattern.
- Output is delivered two ways: a registered parallel thermometer mask, and a serial bit-stream, one bit per cycle, under valid/ready handshake.
- Sits on the NPU test/replay path: regenerates activation bit-vectors from stored counts. Also serves as the stimulus generator for the compressor tree.
- Round-trip property: feeding the emitted mask back into the compressor must return the original count.

Parameters:
- N, 13, number of unary output bits (compressor input width).
- CW, 4, count width; equals clog2(N+1).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, synchronous, active-high.
- in_valid  input  1  in_count is presented.
- in_ready  output  1  block can accept a count.
- in_count  input  CW  population count to expand, legal range 0..N.
- mask  output  N  thermometer mask; bit i = 1 iff i < latched count.
- mask_valid  output  1  mask holds a valid expansion.
- count_err  output  1  last accepted count exceeded N (sticky until next accept).
- bit_valid  output  1  bit_out is valid.
- bit_ready  input  1  downstream consumes bit_out.
- bit_out  output  1  serial unary bit: index 0 first, ones first.
- bit_last  output  1  marks index N-1 of the stream.

Behaviour:
- Reset (synchronous, active-high): state=IDLE, idx=0, cnt=0, mask=0, mask_valid=0, count_err=0, bit_valid=0, bit_out=0, bit_last=0, in_ready=1 in the cycle after rst deasserts.
- rst asserted mid-stream aborts the stream with no further bits; the partial stream is discarded.
- State machine has two states, IDLE and EMIT.
- in_ready = (state==IDLE) && !rst.
- IDLE, accept (in_valid && in_ready at edge t):
  - cnt <= min(in_count, N).
  - count_err <= (in_count > N).
  - mask <= thermometer(min(in_count, N)).
  - mask_valid <= 1.
  - idx <= 0.
  - state <= EMIT.
- Latency: mask, mask_valid and the first serial bit are all visible from cycle t+1.
- EMIT outputs:
  - bit_valid=1.
  - bit_out=(idx<cnt).
  - bit_last=(idx==N-1).
- EMIT stall: if bit_ready=0, idx, bit_out and bit_last are held stable. AXI-style rule: valid never drops without a handshake.
- EMIT advance: on bit_valid && bit_ready, idx <= idx+1. If bit_last, state <= IDLE and idx <= 0.
- mask and mask_valid stay unchanged after the stream ends, until the next accept or reset.
- Throughput: one count per N+1 cycles minimum (N bits plus one IDLE accept cycle). No overlap between streams.
- in_valid while in EMIT is ignored (in_ready=0). Upstream holds in_count.
- Boundaries:
  - count=0: mask=0, stream is all zeros.
  - count=N: mask all ones, stream is all ones.
  - count 14 or 15: saturates to N and sets count_err=1.
  - idx wrap: idx never exceeds N-1.
- A simultaneous last-bit handshake and new in_valid: the new count is accepted only in the following IDLE cycle.

Decomposition:
- Shared package npu_popcnt_pkg holds:
  - N_BITS=13 and CNT_W=4 constants.
  - the state enum {IDLE, EMIT}.
  - a thermometer function used by both this block and the compressor testbench.
- One combinational sub-module, thermo_decode (count in, N-bit mask out, saturating). It is instantiated once for the mask register input.
- FSM, index counter and handshake logic stay in popcount_expander.

Test Plan:
- Reset, then in_count=5 with bit_ready tied 1:
  - mask=13'b0000000011111 at t+1.
  - Stream is 5 ones then 8 zeros.
  - bit_last on the 13th bit.
  - in_ready returns at t+14.
- in_count=0 and in_count=13: masks are 0 and 13'h1FFF, streams are all-0 and all-1, count_err=0.
- in_count=15: mask=13'h1FFF, count_err=1, stream is 13 ones. A following accept of in_count=3 clears count_err.
- Random bit_ready backpressure with in_count=7: bit_out and bit_last are held stable during stalls. Exactly 13 handshakes occur, with ones at indices 0-6.
- rst pulsed at stream index 6 with in_count=9:
  - next cycle has bit_valid=0, mask=0, in_ready=1.
  - a new count=2 then streams correctly from index 0.
- Loopback over all counts 0..13: mask drives the 13-to-4 compressor, and O3..O0 must equal the accepted count every time.
